dmem_arbiter: RTL

//   Shares the single-port data memory (M stage) between the CPU datapath and a DMA requester.
//   CPU accesses are single-cycle passthroughs; DMA runs locked bursts of 1..BURST_MAX beats.

---
 rtl/dmem_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the CPU M stage and a DMA
//   requester. CPU accesses pass straight through in the cycle they are
//   requested; DMA runs locked bursts of 1..BURST_MAX beats. A CPU that has
//   been stalled for STARVE_LIMIT consecutive cycles inside a burst is given
//   one forced yield slot before the burst resumes.
//
//   Optional feature macro: DMEM_ARB_STATS_EN
//     defined   -> 16-bit saturating stall-cycle and beat counters are built
//     undefined -> stat_stall / stat_beats are tied to zero
//
//   Handshake (DMA side): dma_req is a level request held high for the whole
//   burst. dma_beat=1 means the beat presented on dma_addr/dma_wdata/dma_wr
//   was performed on memory this cycle; the requester advances its address
//   after each such beat. A read beat returns data on dma_rdata with
//   dma_rvalid=1 exactly one cycle later. dma_done pulses with the final beat.
//   Dropping dma_req mid-burst aborts it without a beat or dma_done.
//
//   A burst starts on the first IDLE cycle with dma_req=1 and no CPU request,
//   and that cycle already carries the first beat; dma_len is sampled there.
//   If a CPU asserts both cpu_rd and cpu_wr, the read is performed.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BURST_MAX    = 8,
  parameter int STARVE_LIMIT = 4,
  localparam int LEN_W       = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  // CPU port
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // DMA port
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_beat,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              dma_done,
  // Memory port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out,
  // Statistics
  output logic [15:0]       stat_stall,
  output logic [15:0]       stat_beats,
  // Debug: current FSM state (0 IDLE, 1 DMA, 2 YIELD)
  output logic [1:0]        o_dbg_state
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DMA   = 2'd1,
    S_YIELD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [LEN_W-1:0]    r_beats_left;
  logic [LEN_W-1:0]    w_beats_next;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_next;
  logic [WAIT_W-1:0]   w_wait_inc;
  logic [LEN_W-1:0]    w_len_clamped;
  logic                w_cpu_req;
  logic                w_cpu_grant;
  logic                w_dma_beat;
  logic                w_dma_done;
  logic                w_cpu_stall;
  logic                r_dma_rvalid;
  logic [DATA_W-1:0]   r_dma_rdata;

  assign w_cpu_req  = cpu_rd | cpu_wr;
  assign w_wait_inc = r_wait_cnt + WAIT_W'(1);

  // Burst length as sampled at burst start: 0 means one beat, cap at BURST_MAX
  always_comb begin
    w_len_clamped = dma_len;
    if (dma_len == '0) begin
      w_len_clamped = LEN_W'(1);
    end else if (dma_len > LEN_W'(BURST_MAX)) begin
      w_len_clamped = LEN_W'(BURST_MAX);
    end
  end

  // FSM state, remaining beats and starvation counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_beats_left <= '0;
      r_wait_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_beats_left <= w_beats_next;
      r_wait_cnt   <= w_wait_next;
    end
  end

  // Next-state logic and per-cycle grant decision
  always_comb begin
    w_state_next = r_state;
    w_beats_next = r_beats_left;
    w_wait_next  = '0;
    w_cpu_grant  = 1'b0;
    w_dma_beat   = 1'b0;
    w_dma_done   = 1'b0;
    w_cpu_stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cpu_req) begin
          w_cpu_grant = 1'b1;
        end else if (dma_req) begin
          // First beat of the burst happens in this cycle
          w_dma_beat   = 1'b1;
          w_beats_next = w_len_clamped - LEN_W'(1);
          if (w_len_clamped == LEN_W'(1)) begin
            w_dma_done = 1'b1;
          end else begin
            w_state_next = S_DMA;
          end
        end
      end
      S_DMA: begin
        if (!dma_req) begin
          // Abort: memory is free this cycle, so a waiting CPU is served
          w_state_next = S_IDLE;
          w_beats_next = '0;
          w_cpu_grant  = w_cpu_req;
        end else begin
          w_dma_beat   = 1'b1;
          w_beats_next = r_beats_left - LEN_W'(1);
          w_cpu_stall  = w_cpu_req;
          if (w_cpu_req) begin
            w_wait_next = w_wait_inc;
          end
          if (r_beats_left <= LEN_W'(1)) begin
            w_dma_done   = 1'b1;
            w_beats_next = '0;
            w_state_next = S_IDLE;
          end else if (w_cpu_req && (w_wait_inc >= WAIT_W'(STARVE_LIMIT))) begin
            w_state_next = S_YIELD;
          end
        end
      end
      S_YIELD: begin
        // One CPU slot; idle if the CPU has stopped requesting
        w_cpu_grant  = w_cpu_req;
        w_state_next = S_DMA;
      end
      default: begin
        w_state_next = S_IDLE;
        w_beats_next = '0;
      end
    endcase
  end

  // Memory port mux: DMA beat, CPU grant, or fully idle
  always_comb begin
    mem_addr  = '0;
    mem_in    = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (w_dma_beat) begin
      mem_addr  = dma_addr;
      mem_in    = dma_wdata;
      mem_read  = ~dma_wr;
      mem_write = dma_wr;
    end else if (w_cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_in    = cpu_wdata;
      mem_read  = cpu_rd;
      mem_write = cpu_wr & ~cpu_rd;
    end
  end

  // DMA read-data return, one cycle after each read beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dma_rvalid <= 1'b0;
      r_dma_rdata  <= '0;
    end else begin
      r_dma_rvalid <= w_dma_beat & ~dma_wr;
      if (w_dma_beat && !dma_wr) begin
        r_dma_rdata <= mem_out;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat_stall;
  logic [15:0] r_stat_beats;

  // Saturating stall-cycle and beat counters, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_stall <= '0;
      r_stat_beats <= '0;
    end else begin
      if (w_cpu_stall && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
      if (w_dma_beat && (r_stat_beats != 16'hFFFF)) begin
        r_stat_beats <= r_stat_beats + 16'd1;
      end
    end
  end

  assign stat_stall = r_stat_stall;
  assign stat_beats = r_stat_beats;
`else
  assign stat_stall = 16'd0;
  assign stat_beats = 16'd0;
`endif

  assign cpu_rdata   = mem_out;
  assign cpu_stall   = w_cpu_stall;
  assign dma_beat    = w_dma_beat;
  assign dma_done    = w_dma_done;
  assign dma_rvalid  = r_dma_rvalid;
  assign dma_rdata   = r_dma_rdata;
  assign o_dbg_state = r_state;

endmodule
